// File: rtl/arp_cam_pkg.sv
// Shared definitions for the ARP IPv4-to-MAC cache controller: entry layout,
// update response codes, update FSM encoding and the index hash.
package arp_cam_pkg;

  localparam int ENTRY_W   = 81;
  localparam int VALID_BIT = 80;
  localparam int TAG_HI    = 79;
  localparam int TAG_LO    = 48;
  localparam int MAC_HI    = 47;
  localparam int MAC_LO    = 0;

  typedef enum logic [2:0] {
    CODE_NEW      = 3'd0,
    CODE_REFRESH  = 3'd1,
    CODE_EVICT    = 3'd2,
    CODE_DELETED  = 3'd3,
    CODE_DEL_MISS = 3'd4
  } upd_code_e;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_INS_CHK = 3'd2,
    ST_DEL_RD  = 3'd3,
    ST_DEL_CHK = 3'd4,
    ST_DEL_WR  = 3'd5,
    ST_RSP     = 3'd6
  } upd_state_e;

  // Folds the IPv4 key to 16 bits; callers keep the low index bits.
  function automatic logic [15:0] ipHash(input logic [31:0] ip);
    return ip[31:16] ^ ip[15:0];
  endfunction

endpackage

// File: rtl/arp_cam_ctrl_ram.sv
// 1R/1RW cache RAM: registered read port plus a write port that also returns
// the pre-write (read-first) contents of the addressed word one cycle later.
module arp_cam_ctrl_ram #(
  parameter int A = 9,
  parameter int D = 81
) (
  input  logic         Clk,
  input  logic [A-1:0] RdAddr,
  output logic [D-1:0] RdData,
  input  logic         WrEnb,
  input  logic [A-1:0] WrAddr,
  input  logic [D-1:0] WrData,
  output logic [D-1:0] WrDataOut
);

  logic [D-1:0] mem [2**A];

  always_ff @(posedge Clk) begin
    RdData    <= mem[RdAddr];
    WrDataOut <= mem[WrAddr];
    if (WrEnb) mem[WrAddr] <= WrData;
  end

endmodule

// File: rtl/arp_cam_ctrl.sv
// ARP cache lookup/update engine: lookups on the RAM read port, insert/delete
// read-modify-write on the RAM write port, with a flush of every entry after reset.
module arp_cam_ctrl
  import arp_cam_pkg::*;
#(
  parameter int A = 9
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        InitDone,
  input  logic        LkpReqValid,
  output logic        LkpReqReady,
  input  logic [31:0] LkpReqIp,
  output logic        LkpRspValid,
  input  logic        LkpRspReady,
  output logic        LkpRspHit,
  output logic [47:0] LkpRspMac,
  input  logic        UpdReqValid,
  output logic        UpdReqReady,
  input  logic        UpdReqOp,
  input  logic [31:0] UpdReqIp,
  input  logic [47:0] UpdReqMac,
  output logic        UpdRspValid,
  input  logic        UpdRspReady,
  output logic [2:0]  UpdRspCode,
  output logic [31:0] UpdRspEvictIp,
  output upd_state_e  DbgUpdState
);

  // Handshakes: a request transfers on a clock edge where Valid && Ready; a
  // response is offered with Valid and held, unchanged, until Valid && Ready.

  logic [A-1:0]       rdAddr, wrAddr, updIdxNext, updIdx, initCnt;
  logic [ENTRY_W-1:0] rdData, wrData, wrDataOut;
  logic               wrEnb;
  logic               lkpAccept, updAccept, inflight, lkpMatch, oldMatch;
  logic [31:0]        lkpIp, updIp;
  upd_state_e         state;
  upd_code_e          updCode;
  logic               unusedOldMac;

  arp_cam_ctrl_ram #(.A(A), .D(ENTRY_W)) uRam (
    .Clk       (Clk),
    .RdAddr    (rdAddr),
    .RdData    (rdData),
    .WrEnb     (wrEnb),
    .WrAddr    (wrAddr),
    .WrData    (wrData),
    .WrDataOut (wrDataOut)
  );

  assign rdAddr      = A'(ipHash(LkpReqIp));
  assign updIdxNext  = A'(ipHash(UpdReqIp));
  assign LkpReqReady = InitDone && !inflight && !LkpRspValid;
  assign UpdReqReady = InitDone && (state == ST_IDLE);
  assign lkpAccept   = LkpReqValid && LkpReqReady;
  assign updAccept   = UpdReqValid && UpdReqReady;
  assign lkpMatch    = rdData[VALID_BIT] && (rdData[TAG_HI:TAG_LO] == lkpIp);
  assign oldMatch    = wrDataOut[VALID_BIT] && (wrDataOut[TAG_HI:TAG_LO] == updIp);
  assign UpdRspCode  = updCode;
  assign DbgUpdState = state;
  // The old MAC is never inspected by the update FSM.
  assign unusedOldMac = ^wrDataOut[MAC_HI:MAC_LO];

  always_comb begin
    wrEnb  = 1'b0;
    wrAddr = updIdx;
    wrData = '0;
    case (state)
      ST_INIT: begin
        wrEnb  = 1'b1;
        wrAddr = initCnt;
      end
      ST_IDLE: begin
        wrAddr = updIdxNext;
        if (updAccept && !UpdReqOp) begin
          wrEnb  = 1'b1;
          wrData = {1'b1, UpdReqIp, UpdReqMac};
        end
      end
      ST_DEL_WR: wrEnb = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      inflight    <= 1'b0;
      lkpIp       <= '0;
      LkpRspValid <= 1'b0;
      LkpRspHit   <= 1'b0;
      LkpRspMac   <= '0;
    end else begin
      if (inflight) begin
        inflight    <= 1'b0;
        LkpRspValid <= 1'b1;
        LkpRspHit   <= lkpMatch;
        LkpRspMac   <= lkpMatch ? rdData[MAC_HI:MAC_LO] : '0;
      end else if (LkpRspValid && LkpRspReady) begin
        LkpRspValid <= 1'b0;
        LkpRspHit   <= 1'b0;
        LkpRspMac   <= '0;
      end
      if (lkpAccept) begin
        inflight <= 1'b1;
        lkpIp    <= LkpReqIp;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= ST_INIT;
      initCnt       <= '0;
      InitDone      <= 1'b0;
      updIp         <= '0;
      updIdx        <= '0;
      UpdRspValid   <= 1'b0;
      updCode       <= CODE_NEW;
      UpdRspEvictIp <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          initCnt <= initCnt + 1'b1;
          if (&initCnt) begin
            InitDone <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (updAccept) begin
            updIp  <= UpdReqIp;
            updIdx <= updIdxNext;
            state  <= UpdReqOp ? ST_DEL_RD : ST_INS_CHK;
          end
        end
        // wrDataOut now holds the entry this insert just overwrote.
        ST_INS_CHK: begin
          if (!wrDataOut[VALID_BIT]) begin
            updCode <= CODE_NEW;
          end else if (oldMatch) begin
            updCode <= CODE_REFRESH;
          end else begin
            updCode       <= CODE_EVICT;
            UpdRspEvictIp <= wrDataOut[TAG_HI:TAG_LO];
          end
          UpdRspValid <= 1'b1;
          state       <= ST_RSP;
        end
        ST_DEL_RD: state <= ST_DEL_CHK;
        ST_DEL_CHK: begin
          if (oldMatch) begin
            state <= ST_DEL_WR;
          end else begin
            updCode     <= CODE_DEL_MISS;
            UpdRspValid <= 1'b1;
            state       <= ST_RSP;
          end
        end
        ST_DEL_WR: begin
          updCode     <= CODE_DELETED;
          UpdRspValid <= 1'b1;
          state       <= ST_RSP;
        end
        ST_RSP: begin
          if (UpdRspReady) begin
            UpdRspValid   <= 1'b0;
            updCode       <= CODE_NEW;
            UpdRspEvictIp <= '0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_cam_ctrl.sv
// Bench for arp_cam_ctrl: directed and randomized lookups/updates checked
// against a direct-mapped cache model built from the cache rules.
module tb_arp_cam_ctrl;
  import arp_cam_pkg::*;

  localparam int A    = 9;
  localparam int NENT = 1 << A;

  logic        clk, rst_n, init_done;
  logic        lkp_req_valid, lkp_req_ready, lkp_rsp_valid, lkp_rsp_ready, lkp_rsp_hit;
  logic [31:0] lkp_req_ip;
  logic [47:0] lkp_rsp_mac;
  logic        upd_req_valid, upd_req_ready, upd_req_op, upd_rsp_valid, upd_rsp_ready;
  logic [31:0] upd_req_ip, upd_rsp_evict_ip;
  logic [47:0] upd_req_mac;
  logic [2:0]  upd_rsp_code;
  upd_state_e  dbg_state;
  logic [88:0] outs_now;

  int total = 0;
  int bad   = 0;

  // cache model: one slot per index, keyed by the folded IP
  logic        m_valid [NENT];
  logic [31:0] m_ip    [NENT];
  logic [47:0] m_mac   [NENT];

  arp_cam_ctrl #(.A(A)) dut (
    .Clk(clk), .Rst_n(rst_n), .InitDone(init_done),
    .LkpReqValid(lkp_req_valid), .LkpReqReady(lkp_req_ready), .LkpReqIp(lkp_req_ip),
    .LkpRspValid(lkp_rsp_valid), .LkpRspReady(lkp_rsp_ready), .LkpRspHit(lkp_rsp_hit),
    .LkpRspMac(lkp_rsp_mac),
    .UpdReqValid(upd_req_valid), .UpdReqReady(upd_req_ready), .UpdReqOp(upd_req_op),
    .UpdReqIp(upd_req_ip), .UpdReqMac(upd_req_mac),
    .UpdRspValid(upd_rsp_valid), .UpdRspReady(upd_rsp_ready), .UpdRspCode(upd_rsp_code),
    .UpdRspEvictIp(upd_rsp_evict_ip), .DbgUpdState(dbg_state)
  );

  assign outs_now = {init_done, lkp_req_ready, lkp_rsp_valid, lkp_rsp_hit, lkp_rsp_mac,
                     upd_req_ready, upd_rsp_valid, upd_rsp_code, upd_rsp_evict_ip};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic int idx_of(input logic [31:0] ip);
    return int'(ip[31:16] ^ ip[15:0]) % NENT;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0; m_ip[i] = '0; m_mac[i] = '0;
    end
  endtask

  task automatic model_lookup(input logic [31:0] ip, output logic hit, output logic [47:0] mac);
    int k;
    k   = idx_of(ip);
    hit = m_valid[k] && (m_ip[k] == ip);
    mac = hit ? m_mac[k] : 48'h0;
  endtask

  task automatic model_update(input logic op, input logic [31:0] ip, input logic [47:0] mac,
                              output logic [2:0] code, output logic [31:0] evict, output int lat);
    int k;
    k     = idx_of(ip);
    evict = '0;
    if (!op) begin
      lat = 2;
      if (!m_valid[k]) code = 3'd0;
      else if (m_ip[k] == ip) code = 3'd1;
      else begin code = 3'd2; evict = m_ip[k]; end
      m_valid[k] = 1'b1; m_ip[k] = ip; m_mac[k] = mac;
    end else if (m_valid[k] && m_ip[k] == ip) begin
      code = 3'd3; lat = 4; m_valid[k] = 1'b0;
    end else begin
      code = 3'd4; lat = 3;
    end
  endtask

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic release_and_flush(output int cyc, output int early);
    rst_n = 1'b1;
    cyc = 0; early = 0;
    while (!init_done && cyc < 2000) begin
      if (lkp_req_ready || upd_req_ready) early++;
      @(negedge clk); cyc++;
    end
  endtask

  task automatic drv_lookup(input logic [31:0] ip, input int hold, output logic hit,
                            output logic [47:0] mac, output int lat, output int unstable);
    int w;
    w = 0; hit = 1'bx; mac = 'x; lat = -1; unstable = 0;
    lkp_req_valid = 1'b1; lkp_req_ip = ip;
    while (!lkp_req_ready && w < 100) begin @(negedge clk); w++; end
    if (!lkp_req_ready) begin
      total++; bad++;
      $display("FAIL lkp_req_timeout ready=%0b required=1", lkp_req_ready);
      lkp_req_valid = 1'b0; return;
    end
    @(posedge clk); @(negedge clk);
    lkp_req_valid = 1'b0; lkp_req_ip = $urandom;
    lat = 1;
    while (!lkp_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!lkp_rsp_valid) begin
      total++; bad++;
      $display("FAIL lkp_rsp_timeout valid=%0b required=1", lkp_rsp_valid);
      return;
    end
    hit = lkp_rsp_hit; mac = lkp_rsp_mac;
    repeat (hold) begin
      @(negedge clk);
      if (!lkp_rsp_valid || lkp_rsp_hit !== hit || lkp_rsp_mac !== mac || lkp_req_ready) unstable++;
    end
    lkp_rsp_ready = 1'b1; @(posedge clk); @(negedge clk); lkp_rsp_ready = 1'b0;
  endtask

  task automatic drv_update(input logic op, input logic [31:0] ip, input logic [47:0] mac,
                            input int hold, output logic [2:0] code, output logic [31:0] evict,
                            output int lat, output int unstable);
    int w;
    logic [63:0] r;
    w = 0; code = 3'b111; evict = 'x; lat = -1; unstable = 0;
    upd_req_valid = 1'b1; upd_req_op = op; upd_req_ip = ip; upd_req_mac = mac;
    while (!upd_req_ready && w < 100) begin @(negedge clk); w++; end
    if (!upd_req_ready) begin
      total++; bad++;
      $display("FAIL upd_req_timeout ready=%0b required=1", upd_req_ready);
      upd_req_valid = 1'b0; return;
    end
    @(posedge clk); @(negedge clk);
    r = {$urandom, $urandom};
    upd_req_valid = 1'b0; upd_req_ip = r[63:32]; upd_req_mac = r[47:0]; upd_req_op = r[0];
    lat = 1;
    while (!upd_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!upd_rsp_valid) begin
      total++; bad++;
      $display("FAIL upd_rsp_timeout valid=%0b required=1", upd_rsp_valid);
      return;
    end
    code = upd_rsp_code; evict = upd_rsp_evict_ip;
    repeat (hold) begin
      @(negedge clk);
      if (!upd_rsp_valid || upd_rsp_code !== code || upd_rsp_evict_ip !== evict || upd_req_ready)
        unstable++;
    end
    upd_rsp_ready = 1'b1; @(posedge clk); @(negedge clk); upd_rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc, early, lat, uns;
    logic hit; logic [47:0] mac;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (outs_now !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs_now); end
    release_and_flush(cyc, early);
    total++;
    if (cyc !== NENT) begin bad++; $display("FAIL init_latency got=%0d exp=%0d", cyc, NENT); end
    total++;
    if (early !== 0) begin bad++; $display("FAIL ready_before_init got=%0d exp=0", early); end
    model_clear();
    for (int i = 0; i < 4; i++) begin
      drv_lookup($urandom, 0, hit, mac, lat, uns);
      total++;
      if (hit !== 1'b0 || mac !== 48'h0 || lat !== 2) begin
        bad++; $display("FAIL post_init_miss hit=%0b mac=%h lat=%0d exp 0/0/2", hit, mac, lat);
      end
    end
  endtask

  task automatic check_update(input string name, input logic op, input logic [31:0] ip,
                              input logic [47:0] mac, input int hold);
    logic [2:0] code, ecode; logic [31:0] ev, eev; int lat, elat, uns;
    model_update(op, ip, mac, ecode, eev, elat);
    drv_update(op, ip, mac, hold, code, ev, lat, uns);
    total++;
    if (code !== ecode || ev !== eev || lat !== elat || uns !== 0) begin
      bad++;
      $display("FAIL %s code=%0d evict=%h lat=%0d unstable=%0d exp code=%0d evict=%h lat=%0d unstable=0",
               name, code, ev, lat, uns, ecode, eev, elat);
    end
  endtask

  task automatic check_lookup(input string name, input logic [31:0] ip, input int hold);
    logic hit, ehit; logic [47:0] mac, emac; int lat, uns;
    model_lookup(ip, ehit, emac);
    drv_lookup(ip, hold, hit, mac, lat, uns);
    total++;
    if (hit !== ehit || mac !== emac || lat !== 2 || uns !== 0) begin
      bad++;
      $display("FAIL %s hit=%0b mac=%h lat=%0d unstable=%0d exp hit=%0b mac=%h lat=2 unstable=0",
               name, hit, mac, lat, uns, ehit, emac);
    end
  endtask

  task automatic test_insert_lookup();
    check_update("insert_new", 1'b0, 32'h0A000001, 48'h020000000001, 0);
    check_lookup("lookup_hit", 32'h0A000001, 0);
    check_update("insert_refresh", 1'b0, 32'h0A000001, 48'h0200000000AB, 0);
    check_lookup("lookup_refreshed", 32'h0A000001, 0);
  endtask

  task automatic test_evict();
    check_update("insert_evict", 1'b0, 32'h0A000201, 48'h020000000201, 0);
    check_lookup("lookup_evicted", 32'h0A000001, 0);
    check_lookup("lookup_evictor", 32'h0A000201, 0);
  endtask

  task automatic test_delete();
    check_update("delete_hit", 1'b1, 32'h0A000201, 48'h0, 0);
    check_update("delete_again", 1'b1, 32'h0A000201, 48'h0, 0);
    check_update("reinsert", 1'b0, 32'h0A000201, 48'h0000C0FFEE00, 0);
    check_update("delete_other_tag", 1'b1, 32'h0A000001, 48'h0, 0);
    check_lookup("lookup_untouched", 32'h0A000201, 0);
  endtask

  task automatic test_hold();
    check_update("hold_update", 1'b0, 32'hC0A80105, 48'h1234567890AB, 10);
    check_lookup("hold_lookup", 32'hC0A80105, 10);
    check_lookup("after_hold", 32'h0A000201, 0);
  endtask

  task automatic test_concurrent();
    logic [2:0] code, ecode; logic [31:0] ev, eev; int lat, elat, uns_u, uns_l, llat;
    logic hit, ehit; logic [47:0] mac, emac;
    model_lookup(32'h0A000201, ehit, emac);
    model_update(1'b0, 32'hAC100020, 48'hAABBCCDDEEFF, ecode, eev, elat);
    fork
      drv_update(1'b0, 32'hAC100020, 48'hAABBCCDDEEFF, 0, code, ev, lat, uns_u);
      drv_lookup(32'h0A000201, 0, hit, mac, llat, uns_l);
    join
    total++;
    if (code !== ecode || ev !== eev || lat !== elat || hit !== ehit || mac !== emac || llat !== 2) begin
      bad++;
      $display("FAIL concurrent code=%0d lat=%0d hit=%0b mac=%h llat=%0d exp %0d/%0d/%0b/%h/2",
               code, lat, hit, mac, llat, ecode, elat, ehit, emac);
    end
  endtask

  task automatic test_random();
    logic [8:0] pool [4];
    logic [15:0] hi, lo;
    logic [31:0] ip;
    logic [63:0] r;
    pool[0] = 9'h001; pool[1] = 9'h1FF; pool[2] = 9'h0AB; pool[3] = 9'h100;
    for (int n = 0; n < 200; n++) begin
      hi = 16'h0A00 + 16'($urandom_range(0, 2));
      lo = hi ^ {7'b0, pool[$urandom_range(0, 3)]};
      ip = {hi, lo};
      r  = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: check_update("rand_insert", 1'b0, ip, r[47:0], $urandom_range(0, 2));
        1: check_update("rand_delete", 1'b1, ip, r[47:0], $urandom_range(0, 2));
        default: check_lookup("rand_lookup", ip, $urandom_range(0, 2));
      endcase
    end
  endtask

  task automatic test_reset_mid_init();
    int cyc, early;
    rst_n = 1'b0; @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (outs_now !== '0 || dbg_state !== ST_INIT) begin
      bad++; $display("FAIL mid_init_reset outs=%h state=%0d exp 0/%0d", outs_now, dbg_state, ST_INIT);
    end
    @(negedge clk);
    release_and_flush(cyc, early);
    total++;
    if (cyc !== NENT || early !== 0) begin
      bad++; $display("FAIL mid_init_reflush cycles=%0d early=%0d exp %0d/0", cyc, early, NENT);
    end
    model_clear();
    check_lookup("mid_init_empty", 32'h0A000201, 0);
  endtask

  task automatic test_reset_mid_delete();
    int w, cyc, early;
    check_update("pre_delete_insert", 1'b0, 32'h0A000001, 48'h020000000001, 0);
    check_update("pre_delete_insert2", 1'b0, 32'hC0A80105, 48'h1234567890AB, 0);
    upd_req_valid = 1'b1; upd_req_op = 1'b1; upd_req_ip = 32'h0A000001;
    w = 0;
    while (!upd_req_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); @(negedge clk);
    upd_req_valid = 1'b0;
    w = 0;
    while (dbg_state !== ST_DEL_CHK && w < 10) begin @(negedge clk); w++; end
    total++;
    if (dbg_state !== ST_DEL_CHK) begin
      bad++; $display("FAIL reach_del_chk state=%0d exp=%0d", dbg_state, ST_DEL_CHK);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (outs_now !== '0 || dbg_state !== ST_INIT) begin
      bad++; $display("FAIL mid_delete_reset outs=%h state=%0d exp 0/%0d", outs_now, dbg_state, ST_INIT);
    end
    @(negedge clk);
    release_and_flush(cyc, early);
    total++;
    if (cyc !== NENT || early !== 0) begin
      bad++; $display("FAIL mid_delete_reflush cycles=%0d early=%0d exp %0d/0", cyc, early, NENT);
    end
    model_clear();
    check_lookup("flushed_entry_a", 32'h0A000001, 0);
    check_lookup("flushed_entry_b", 32'hC0A80105, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    lkp_req_valid = 1'b0; lkp_req_ip = '0; lkp_rsp_ready = 1'b0;
    upd_req_valid = 1'b0; upd_req_op = 1'b0; upd_req_ip = '0; upd_req_mac = '0;
    upd_rsp_ready = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_insert_lookup();
    test_evict();
    test_delete();
    test_hold();
    test_concurrent();
    test_random();
    test_reset_mid_init();
    test_reset_mid_delete();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
